signal_debouncer: RTL and testbench

- Upstream conditioning stage for positive_edge_detector.
- Takes a raw asynchronous level input (button, switch, external strobe), synchronizes it to clk, and filters bounce.
- Presents a clean, single-transition level on `signal`; downstream edge detection then yields exactly one pulse per real press.

---
 rtl/signal_debouncer.sv | 181 ++++++++++++++++++
 tb/tb_signal_debouncer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_debouncer.sv
// -----------------------------------------------------------------------------
// signal_debouncer
//
// Purpose:
//   Conditions a raw asynchronous level (button, switch, external strobe) for
//   clk-domain logic. The input is synchronized through a flop chain, and a
//   four-state FSM then requires STABLE_CYCLES consecutive synchronized
//   samples at a new level before the debounced output follows it. The output
//   therefore makes one clean transition per real change. A downstream
//   positive_edge_detector sees exactly one pulse per press.
//
// Parameters:
//   STABLE_CYCLES : consecutive synchronized cycles needed at a new level
//                   (2..65535).
//   CNT_W         : stability counter width; 2**CNT_W must exceed
//                   STABLE_CYCLES.
//
// Ports:
//   clk       in   system clock; all state updates on the rising edge.
//   rst       in   synchronous active-high reset; it overrides every transition.
//   signal_in in   raw asynchronous input level.
//   signal    out  debounced, registered level.
//   busy      out  registered; high while a candidate transition is being
//                  qualified (WAIT_HIGH / WAIT_LOW).
//
// Build option:
//   SIGNAL_DEBOUNCER_SYNC3_EN - when defined, a third synchronizer flop is
//   added. The FSM then reads the third flop, and every latency grows by one
//   cycle. When undefined, a two-flop chain is used.
// -----------------------------------------------------------------------------
module signal_debouncer #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic signal,
    output logic busy
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    // Terminal count: the sample that completes qualification arrives while
    // the counter holds STABLE_CYCLES-1. The counter therefore never wraps.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             signal_r;
    logic             signal_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;

`ifdef SIGNAL_DEBOUNCER_SYNC3_EN
    logic             sync3_r;

    // Three-flop synchronizer chain for the raw asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= signal_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign level_s = sync3_r;
`else
    // Two-flop synchronizer chain for the raw asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= signal_in;
            sync2_r <= sync1_r;
        end
    end

    assign level_s = sync2_r;
`endif

    // FSM next-state, stability counter and registered-output next values.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        signal_nxt_s = signal_r;

        case (state_r)
            STABLE_LOW: begin
                if (level_s) begin
                    // The first high sample counts as cycle 1 of the run.
                    state_nxt_s = WAIT_HIGH;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            WAIT_HIGH: begin
                if (!level_s) begin
                    // Abort: the output was never touched, so it stays low.
                    state_nxt_s = STABLE_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == LAST_CNT) begin
                    state_nxt_s  = STABLE_HIGH;
                    cnt_nxt_s    = CNT_ZERO;
                    signal_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!level_s) begin
                    state_nxt_s = WAIT_LOW;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            WAIT_LOW: begin
                if (level_s) begin
                    state_nxt_s = STABLE_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == LAST_CNT) begin
                    state_nxt_s  = STABLE_LOW;
                    cnt_nxt_s    = CNT_ZERO;
                    signal_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s  = STABLE_LOW;
                cnt_nxt_s    = CNT_ZERO;
                signal_nxt_s = 1'b0;
            end
        endcase

        if ((state_nxt_s == WAIT_HIGH) || (state_nxt_s == WAIT_LOW)) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // State, counter and output registers; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= STABLE_LOW;
            cnt_r    <= CNT_ZERO;
            signal_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            signal_r <= signal_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign signal = signal_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_signal_debouncer.sv
// -----------------------------------------------------------------------------
// tb_signal_debouncer
//
// Self-checking bench for signal_debouncer with STABLE_CYCLES = 4.
//
// The reference model works on sampled levels. The synchronizer is a
// fixed-length delay line of raw samples. The filter is a run-length counter:
// the output flips once the delayed level has differed from the output for S
// consecutive edges, and busy means that such a run is in progress.
//
// Scenario tasks also check the fixed edge numbers from the test plan. The
// define SIGNAL_DEBOUNCER_SYNC3_EN shifts those edge numbers by one.
// -----------------------------------------------------------------------------
module tb_signal_debouncer;

    localparam int S = 4;
`ifdef SIGNAL_DEBOUNCER_SYNC3_EN
    localparam int SD = 3;
`else
    localparam int SD = 2;
`endif

    logic clk;
    logic rst;
    logic signal_in;
    logic signal;
    logic busy;

    int n_tests;
    int n_fail;
    int rises;
    logic prev_sig;

    // Reference model state.
    bit m_q[$];
    bit m_out;
    int m_run;

    signal_debouncer #(
        .STABLE_CYCLES(S),
        .CNT_W        (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .signal_in(signal_in),
        .signal   (signal),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < SD; i++) m_q.push_back(1'b0);
        m_out = 1'b0;
        m_run = 0;
    endtask

    // Advance one rising edge. Update the model with the inputs present at that
    // edge. Sample the DUT 1 time unit later.
    task automatic tick();
        bit lvl;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            lvl = m_q.pop_front();
            m_q.push_back(signal_in);
            if (lvl != m_out) begin
                m_run++;
                if (m_run == S) begin
                    m_out = lvl;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
        if (signal && !prev_sig) rises++;
        prev_sig = signal;
    endtask

    task automatic go_idle();
        rst = 1'b1;
        signal_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < SD + 2; i++) tick();
        rises = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        signal_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (signal !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: signal=%0b busy=%0b expected 0 0", signal, busy);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= SD + S + 1; e++) begin
            tick();
            n_tests++;
            if (signal !== ((e >= SD + S) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: signal=%0b expected %0b",
                         e, signal, (e >= SD + S));
            end
        end
    endtask

    task automatic test_clean_press();
        go_idle();
        signal_in = 1'b1;
        for (int e = 0; e < SD + S + 4; e++) begin
            tick();
            n_tests++;
            if (signal !== ((e >= SD - 1 + S) ? 1'b1 : 1'b0) ||
                busy !== ((e >= SD && e < SD - 1 + S) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: signal=%0b busy=%0b expected %0b %0b",
                         e, signal, busy, (e >= SD - 1 + S), (e >= SD && e < SD - 1 + S));
            end
        end
        n_tests++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL clean_press_pulses: got %0d expected 1", rises);
        end
    endtask

    task automatic test_bounce_reject();
        int busy_seen;
        busy_seen = 0;
        go_idle();
        for (int e = 0; e < 20; e++) begin
            signal_in = (e < 8) ? ((e / 2) % 2 == 0) : 1'b0;
            tick();
            if (busy) busy_seen++;
            n_tests++;
            if (signal !== 1'b0 || busy !== (m_run != 0)) begin
                n_fail++;
                $display("FAIL bounce_reject edge %0d: signal=%0b busy=%0b expected 0 %0b",
                         e, signal, busy, (m_run != 0));
            end
        end
        n_tests++;
        if (busy_seen == 0 || rises !== 0) begin
            n_fail++;
            $display("FAIL bounce_reject_summary: busy_cycles=%0d pulses=%0d expected >0 and 0",
                     busy_seen, rises);
        end
    endtask

    task automatic test_bounce_settle();
        go_idle();
        for (int e = 0; e < 16; e++) begin
            signal_in = (e == 3) ? 1'b0 : 1'b1;
            tick();
            n_tests++;
            if (signal !== ((e >= 4 + SD - 1 + S) ? 1'b1 : 1'b0) || signal !== m_out) begin
                n_fail++;
                $display("FAIL bounce_settle edge %0d: signal=%0b expected %0b",
                         e, signal, (e >= 4 + SD - 1 + S));
            end
        end
        n_tests++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL bounce_settle_pulses: got %0d expected 1", rises);
        end
    endtask

    task automatic test_release();
        go_idle();
        signal_in = 1'b1;
        for (int i = 0; i < SD + S + 2; i++) tick();
        signal_in = 1'b0;
        for (int e = 0; e < SD + S + 3; e++) begin
            tick();
            n_tests++;
            if (signal !== ((e >= SD - 1 + S) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL release edge %0d: signal=%0b expected %0b",
                         e, signal, !(e >= SD - 1 + S));
            end
        end
        signal_in = 1'b1;
        for (int i = 0; i < SD + S + 2; i++) tick();
        for (int e = 0; e < 14; e++) begin
            signal_in = (e < 3) ? 1'b0 : 1'b1;
            tick();
            n_tests++;
            if (signal !== 1'b1) begin
                n_fail++;
                $display("FAIL release_glitch edge %0d: signal=%0b expected 1", e, signal);
            end
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        signal_in = 1'b1;
        for (int i = 0; i < SD + 2; i++) tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy: busy=%0b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (signal !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: signal=%0b busy=%0b expected 0 0", signal, busy);
        end
        rst = 1'b0;
        for (int e = 1; e <= SD + S; e++) begin
            tick();
            n_tests++;
            if (signal !== ((e == SD + S) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL reset_mid_requal edge %0d: signal=%0b expected %0b",
                         e, signal, (e == SD + S));
            end
        end
    endtask

    task automatic test_random();
        int run_len;
        run_len = 0;
        go_idle();
        for (int c = 0; c < 800; c++) begin
            if (run_len == 0) begin
                signal_in = $urandom_range(1, 0);
                run_len = $urandom_range(2 * S + 2, 1);
            end
            run_len--;
            rst = ($urandom_range(59, 0) == 0);
            tick();
            n_tests++;
            if (signal !== m_out || busy !== (m_run != 0)) begin
                n_fail++;
                $display("FAIL random cycle %0d: signal=%0b busy=%0b expected %0b %0b",
                         c, signal, busy, m_out, (m_run != 0));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rises = 0;
        prev_sig = 1'b0;
        rst = 1'b1;
        signal_in = 1'b0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_bounce_settle();
        test_release();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
